// File: rtl/sccb_slave_rx_pkg.sv
// sccb_slave_rx_pkg: FSM state type and default device ID shared by the SCCB slave and master
package sccb_slave_rx_pkg;
  typedef enum logic [2:0] {
    IDLE, ID_BYTE, ID_ACK, ADDR_BYTE, ADDR_ACK, DATA_BYTE, DATA_ACK, WAIT_STOP
  } state_e;
  localparam logic [7:0] DEFAULT_DEVICE_ID = 8'h42;
endpackage

// File: rtl/sccb_slave_rx_sync_edge.sv
// sccb_slave_rx_sync_edge: bus-line synchronizer with glitch filter and rise/fall flags
//   clk, reset : system clock, sync active-high reset (stages and history load 1)
//   din        : asynchronous bus line
//   dout       : filtered synchronized level
//   rise, fall : one-clk edge flags of dout
module sccb_slave_rx_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;
  // The level only moves once every stage agrees, so a pulse seen by a single
  // sampling edge never reaches the edge detectors.
  always_comb begin
    sync_d = STAGES'({sync_q, din});
    dout   = (&sync_q || ~|sync_q) ? sync_q[STAGES-1] : hist_q;
    hist_d = dout;
    rise   = dout && !hist_q;
    fall   = !dout && hist_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end
endmodule

// File: rtl/sccb_slave_rx.sv
// sccb_slave_rx: SCCB write slave receiving ID, register address and data with open-drain ACK
//   clk, reset             : system clock, sync active-high reset
//   sccb_clk               : SIO_C from the master (asynchronous)
//   io_sio_d               : SIO_D, driven low during ACK, otherwise released
//   o_wr_en                : one-clk strobe, o_reg_addr/o_reg_data valid with it
//   o_reg_addr, o_reg_data : last received address and data
//   o_busy                 : transaction in progress
//   o_id_error             : one-clk strobe on an ID byte not matching DEVICE_ID
module sccb_slave_rx
  import sccb_slave_rx_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID   = DEFAULT_DEVICE_ID,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sccb_clk,
  inout  wire        io_sio_d,
  output logic       o_wr_en,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_data,
  output logic       o_busy,
  output logic       o_id_error
);
  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d, addr_q, addr_d, data_q, data_d, rx_byte;
  logic       ack_q, ack_d, wr_en_q, wr_en_d, id_err_q, id_err_d;
  logic       c_hi, c_rise, c_fall, d_hi, d_rise, d_fall;
  logic       start, stop, in_byte, in_ack, id_ok;
  sccb_slave_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_c (
    .clk(clk), .reset(reset), .din(sccb_clk), .dout(c_hi), .rise(c_rise), .fall(c_fall)
  );
  sccb_slave_rx_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_d (
    .clk(clk), .reset(reset), .din(io_sio_d), .dout(d_hi), .rise(d_rise), .fall(d_fall)
  );
  assign start   = d_fall && c_hi;
  assign stop    = d_rise && c_hi;
  assign in_byte = state_q == ID_BYTE || state_q == ADDR_BYTE || state_q == DATA_BYTE;
  assign in_ack  = state_q == ID_ACK || state_q == ADDR_ACK || state_q == DATA_ACK;
  assign rx_byte = {shift_q[6:0], d_hi};
  assign id_ok   = rx_byte == DEVICE_ID;
  // ack_q toggles on each SIO_C fall in an ACK state: the first fall starts
  // pulling SIO_D low, the second releases it and moves to the next phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    ack_d    = ack_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_en_d  = 1'b0;
    id_err_d = 1'b0;
    if (start || stop) begin
      state_d = start ? ID_BYTE : IDLE;
      cnt_d   = '0;
      shift_d = '0;
      ack_d   = 1'b0;
    end else if (c_rise && in_byte) begin
      shift_d = rx_byte;
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        state_d  = state_q == ID_BYTE ? (id_ok ? ID_ACK : WAIT_STOP) :
                   state_q == ADDR_BYTE ? ADDR_ACK : DATA_ACK;
        id_err_d = state_q == ID_BYTE && !id_ok;
        addr_d   = state_q == ADDR_BYTE ? rx_byte : addr_q;
        data_d   = state_q == DATA_BYTE ? rx_byte : data_q;
        wr_en_d  = state_q == DATA_BYTE;
      end
    end else if (c_fall && in_ack) begin
      ack_d = !ack_q;
      if (ack_q)
        state_d = state_q == ID_ACK ? ADDR_BYTE : state_q == ADDR_ACK ? DATA_BYTE : WAIT_STOP;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      ack_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_en_q  <= 1'b0;
      id_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      ack_q    <= ack_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_en_q  <= wr_en_d;
      id_err_q <= id_err_d;
    end
  end
  assign io_sio_d   = ack_q ? 1'b0 : 1'bz;
  assign o_wr_en    = wr_en_q;
  assign o_reg_addr = addr_q;
  assign o_reg_data = data_q;
  assign o_busy     = state_q != IDLE;
  assign o_id_error = id_err_q;
endmodule

// File: tb/tb_sccb_slave_rx.sv
// tb_sccb_slave_rx: SCCB master model driving sccb_slave_rx, checked against expected transaction outcomes
module tb_sccb_slave_rx;
  localparam logic [7:0] DEV = 8'h42;
  logic       clk = 1'b0, reset = 1'b1, scl = 1'b1, sda_low = 1'b0;
  wire        sio_d;
  logic       wr_en, busy, id_err;
  logic [7:0] reg_addr, reg_data, cap_addr = '0, cap_data = '0, exp_addr = '0, exp_data = '0;
  int         errors = 0, checks = 0, wr_cnt = 0, id_cnt = 0, hp = 16;
  assign sio_d = sda_low ? 1'b0 : 1'bz;
  pullup (sio_d);
  always #5 clk = ~clk;
  sccb_slave_rx #(.DEVICE_ID(DEV), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sccb_clk(scl), .io_sio_d(sio_d), .o_wr_en(wr_en),
    .o_reg_addr(reg_addr), .o_reg_data(reg_data), .o_busy(busy), .o_id_error(id_err)
  );
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      cap_addr = reg_addr;
      cap_data = reg_data;
    end
    if (id_err) id_cnt++;
  end
  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    w(hp / 2); sda_low = ~b; w(hp - hp / 2); scl = 1'b1; w(hp); scl = 1'b0;
  endtask
  task automatic ack_slot(output logic acked);
    w(hp / 2); sda_low = 1'b0; w(hp - hp / 2); scl = 1'b1;
    w(hp / 2); acked = sio_d === 1'b0; w(hp - hp / 2); scl = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_slot(acked);
  endtask
  task automatic do_start;
    if (scl === 1'b0) begin
      w(hp / 2); sda_low = 1'b0; w(hp - hp / 2); scl = 1'b1;
    end
    w(hp); sda_low = 1'b1; w(hp); scl = 1'b0;
  endtask
  task automatic do_stop;
    w(hp / 2); sda_low = 1'b1; w(hp - hp / 2); scl = 1'b1; w(hp); sda_low = 1'b0; w(hp);
  endtask
  task automatic write_txn(input logic [7:0] id, a, d, input logic stop, output logic [2:0] acks);
    do_start;
    send_byte(id, acks[2]);
    send_byte(a, acks[1]);
    send_byte(d, acks[0]);
    if (stop) do_stop;
  endtask

  task automatic test_reset;
    w(6);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (id_err !== 1'b0) begin errors++; $display("FAIL reset_id_err got=%b exp=0", id_err); end
    checks++; if (reg_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", reg_addr); end
    checks++; if (reg_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", reg_data); end
    checks++; if (sio_d !== 1'b1) begin errors++; $display("FAIL reset_sio_d got=%b exp=1(released)", sio_d); end
    reset = 1'b0;
    w(6);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic_write;
    logic [2:0] acks;
    int wr0, id0;
    wr0 = wr_cnt; id0 = id_cnt; hp = 500;
    write_txn(DEV, 8'h12, 8'h80, 1'b1, acks);
    w(4); hp = 16;
    exp_addr = 8'h12; exp_data = 8'h80;
    checks++; if (acks !== 3'b111) begin errors++; $display("FAIL basic_acks got=%b exp=111", acks); end
    checks++; if (wr_cnt - wr0 != 1) begin errors++; $display("FAIL basic_wr_cnt got=%0d exp=1", wr_cnt - wr0); end
    checks++; if (cap_addr !== 8'h12) begin errors++; $display("FAIL basic_addr got=%h exp=12", cap_addr); end
    checks++; if (cap_data !== 8'h80) begin errors++; $display("FAIL basic_data got=%h exp=80", cap_data); end
    checks++; if (id_cnt != id0) begin errors++; $display("FAIL basic_id_err got=%0d exp=0", id_cnt - id0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", busy); end
  endtask

  task automatic test_id_error;
    logic [2:0] acks;
    int wr0, id0;
    wr0 = wr_cnt; id0 = id_cnt;
    write_txn(8'h60, 8'h21, 8'h33, 1'b0, acks);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL iderr_busy_before_stop got=%b exp=1", busy); end
    do_stop;
    w(4);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL iderr_busy_after_stop got=%b exp=0", busy); end
    checks++; if (acks !== 3'b000) begin errors++; $display("FAIL iderr_acks got=%b exp=000", acks); end
    checks++; if (id_cnt - id0 != 1) begin errors++; $display("FAIL iderr_pulses got=%0d exp=1", id_cnt - id0); end
    checks++; if (wr_cnt != wr0) begin errors++; $display("FAIL iderr_wr_cnt got=%0d exp=0", wr_cnt - wr0); end
    checks++; if (reg_addr !== exp_addr) begin errors++; $display("FAIL iderr_addr got=%h exp=%h", reg_addr, exp_addr); end
  endtask

  task automatic test_abort_stop;
    logic a0, a1;
    logic [7:0] d;
    int wr0;
    wr0 = wr_cnt;
    d = ~exp_data;
    do_start;
    send_byte(DEV, a0);
    send_byte(exp_addr, a1);
    for (int i = 7; i >= 4; i--) send_bit(d[i]);
    do_stop;
    w(4);
    checks++; if ({a0, a1} !== 2'b11) begin errors++; $display("FAIL abort_acks got=%b exp=11", {a0, a1}); end
    checks++; if (wr_cnt != wr0) begin errors++; $display("FAIL abort_wr_cnt got=%0d exp=0", wr_cnt - wr0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (reg_addr !== exp_addr) begin errors++; $display("FAIL abort_addr got=%h exp=%h", reg_addr, exp_addr); end
    checks++; if (reg_data !== exp_data) begin errors++; $display("FAIL abort_data got=%h exp=%h", reg_data, exp_data); end
  endtask

  task automatic test_repeated_start;
    logic a0, a1;
    logic [2:0] acks;
    int wr0;
    wr0 = wr_cnt;
    do_start;
    send_byte(DEV, a0);
    send_byte(8'h77, a1);
    write_txn(DEV, 8'h3A, 8'h04, 1'b1, acks);
    w(4);
    exp_addr = 8'h3A; exp_data = 8'h04;
    checks++; if ({a0, a1, acks} !== 5'b11111) begin errors++; $display("FAIL rstart_acks got=%b exp=11111", {a0, a1, acks}); end
    checks++; if (wr_cnt - wr0 != 1) begin errors++; $display("FAIL rstart_wr_cnt got=%0d exp=1", wr_cnt - wr0); end
    checks++; if (cap_addr !== 8'h3A) begin errors++; $display("FAIL rstart_addr got=%h exp=3a", cap_addr); end
    checks++; if (cap_data !== 8'h04) begin errors++; $display("FAIL rstart_data got=%h exp=04", cap_data); end
  endtask

  task automatic test_reset_mid;
    logic a0, stray;
    logic [2:0] acks;
    int wr0;
    wr0 = wr_cnt;
    do_start;
    send_byte(DEV, a0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    reset = 1'b1; scl = 1'b1; sda_low = 1'b0;
    w(4);
    exp_addr = 8'h00; exp_data = 8'h00;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (reg_addr !== exp_addr) begin errors++; $display("FAIL rmid_addr got=%h exp=00", reg_addr); end
    checks++; if (reg_data !== exp_data) begin errors++; $display("FAIL rmid_data got=%h exp=00", reg_data); end
    checks++; if (sio_d !== 1'b1) begin errors++; $display("FAIL rmid_sio_d got=%b exp=1(released)", sio_d); end
    reset = 1'b0;
    w(6);
    scl = 1'b0;
    send_byte(DEV, stray);
    scl = 1'b1;
    w(hp);
    checks++; if (stray !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_no_start ack=%b busy=%b exp=0,0", stray, busy); end
    write_txn(DEV, 8'h11, 8'h00, 1'b1, acks);
    w(4);
    exp_addr = 8'h11; exp_data = 8'h00;
    checks++; if (wr_cnt - wr0 != 1) begin errors++; $display("FAIL rmid_wr_cnt got=%0d exp=1", wr_cnt - wr0); end
    checks++; if (acks !== 3'b111) begin errors++; $display("FAIL rmid_acks got=%b exp=111", acks); end
    checks++; if (cap_addr !== 8'h11 || cap_data !== 8'h00) begin errors++; $display("FAIL rmid_write got=%h/%h exp=11/00", cap_addr, cap_data); end
  endtask

  task automatic test_glitch;
    logic a0, a1, a2;
    logic [7:0] d;
    int wr0;
    wr0 = wr_cnt;
    d = 8'h5C;
    w(10); sda_low = 1'b1; w(1); sda_low = 1'b0; w(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_start got busy=%b exp=0", busy); end
    do_start;
    send_byte(DEV, a0);
    send_byte(8'hC3, a1);
    w(hp / 2); sda_low = 1'b1; w(hp - hp / 2); scl = 1'b1;
    w(hp / 2); sda_low = 1'b0; w(1); sda_low = 1'b1; w(hp - hp / 2 - 1); scl = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_stop got busy=%b exp=1", busy); end
    for (int i = 6; i >= 0; i--) send_bit(d[i]);
    ack_slot(a2);
    do_stop;
    w(4);
    exp_addr = 8'hC3; exp_data = d;
    checks++; if (wr_cnt - wr0 != 1) begin errors++; $display("FAIL glitch_wr_cnt got=%0d exp=1", wr_cnt - wr0); end
    checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL glitch_acks got=%b exp=111", {a0, a1, a2}); end
    checks++; if (cap_addr !== exp_addr || cap_data !== exp_data) begin errors++; $display("FAIL glitch_write got=%h/%h exp=%h/%h", cap_addr, cap_data, exp_addr, exp_data); end
  endtask

  task automatic test_random;
    logic [7:0] id, a, d;
    logic [2:0] acks;
    logic ok;
    int wr0, id0;
    for (int n = 0; n < 6; n++) begin
      hp = $urandom_range(12, 24);
      id = ($urandom_range(0, 2) == 0) ? 8'($urandom) : DEV;
      if (n == 1) id = DEV | 8'h01;
      a = 8'($urandom); d = 8'($urandom);
      wr0 = wr_cnt; id0 = id_cnt;
      write_txn(id, a, d, 1'b1, acks);
      w(4);
      ok = id == DEV;
      if (ok) begin exp_addr = a; exp_data = d; end
      checks++; if (acks !== (ok ? 3'b111 : 3'b000)) begin errors++; $display("FAIL rand%0d_acks got=%b id=%h", n, acks, id); end
      checks++; if (wr_cnt - wr0 != (ok ? 1 : 0)) begin errors++; $display("FAIL rand%0d_wr_cnt got=%0d exp=%0d", n, wr_cnt - wr0, ok ? 1 : 0); end
      checks++; if (id_cnt - id0 != (ok ? 0 : 1)) begin errors++; $display("FAIL rand%0d_id_err got=%0d exp=%0d", n, id_cnt - id0, ok ? 0 : 1); end
      checks++; if (reg_addr !== exp_addr || reg_data !== exp_data) begin errors++; $display("FAIL rand%0d_regs got=%h/%h exp=%h/%h", n, reg_addr, reg_data, exp_addr, exp_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_busy got=%b exp=0", n, busy); end
    end
    hp = 16;
  endtask

  initial begin
    test_reset;
    test_basic_write;
    test_id_error;
    test_abort_stop;
    test_repeated_start;
    test_reset_mid;
    test_glitch;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sccb_slave_rx.md
SCCB_SLAVE_RX -- requirements
Module: SCCB_Slave_Rx

Interface
REQ-001 Parameter: DEVICE_ID, 8'h42, 8-bit write ID; bit 0 is the R/W bit, 0 = write.
REQ-002 Parameter: SYNC_STAGES, 2, synchronizer depth for the SIO_C and SIO_D inputs.
REQ-003 Port: clk  input  1  system clock (100 MHz); the only clock in the block.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: sccb_clk  input  1  SIO_C from the master, asynchronous to clk.
REQ-006 Port: io_sio_d  inout  1  SIO_D; the block drives 0 or Z only, never 1.
REQ-007 Port: o_wr_en  output  1  one-clk strobe; o_reg_addr/o_reg_data valid in that cycle.
REQ-008 Port: o_reg_addr  output  8  received register address.
REQ-009 Port: o_reg_data  output  8  received write data.
REQ-010 Port: o_busy  output  1  high from detected START until STOP or abort.
REQ-011 Port: o_id_error  output  1  one-clk strobe when an ID byte mismatches DEVICE_ID.

Function
REQ-012 SIO_C and SIO_D each pass through SYNC_STAGES flops plus one history flop; all decisions use the synchronized signals (bus-to-decision latency SYNC_STAGES+1 clk).
REQ-013 START: synchronized SIO_D falls while synchronized SIO_C is high; STOP: SIO_D rises while SIO_C is high.
REQ-014 Data bits: sample SIO_D on the synchronized SIO_C rising edge, MSB first, with a 3-bit counter of 0..7.
REQ-015 FSM states: IDLE, ID_BYTE, ID_ACK, ADDR_BYTE, ADDR_ACK, DATA_BYTE, DATA_ACK, WAIT_STOP.
REQ-016 IDLE -> ID_BYTE on START; bit counter and shift register clear.
REQ-017 ID byte handling after 8 bits:
- Match with DEVICE_ID -> ID_ACK.
- Mismatch -> o_id_error pulse, then WAIT_STOP with SIO_D released (NACK).
REQ-018 ACK drive and phase exit:
- In each *_ACK state, drive SIO_D low starting at the first SIO_C falling edge after bit 8.
- Release SIO_D at the following SIO_C falling edge.
- Leave the ACK state at that same falling edge: ID_ACK -> ADDR_BYTE, ADDR_ACK -> DATA_BYTE, DATA_ACK -> WAIT_STOP.
REQ-019 The 8th address bit loads o_reg_addr; the 8th data bit loads o_reg_data, and o_wr_en pulses in the next clk.
REQ-020 o_wr_en and o_id_error are each exactly one clk wide, once per qualifying byte.
REQ-021 WAIT_STOP: ignore SIO_C edges and hold SIO_D released; STOP -> IDLE.
REQ-022 STOP in any non-IDLE state -> IDLE, release SIO_D, no o_wr_en; a partial transaction is discarded.
REQ-023 START in any non-IDLE state (repeated start) -> ID_BYTE with the counter cleared; o_reg_addr/o_reg_data keep their last values.
REQ-024 START and STOP take priority over a simultaneous SIO_C edge.
REQ-025 SIO_D output enable is asserted only in *_ACK states during the ACK window.
REQ-026 o_busy = (state != IDLE).

Reset
REQ-027 While reset is high:
- State returns to IDLE.
- The bit counter and shift register clear.
- The synchronizers load 1 (idle bus).
REQ-028 Output values during and after reset: o_reg_addr = 0, o_reg_data = 0, o_wr_en = 0, o_id_error = 0, o_busy = 0, SIO_D = Z.
REQ-029 Reset asserted mid-transfer aborts the transfer with no write strobe; the block re-arms only on a new START after reset.

Structure
REQ-030 SCCB_pkg holds the FSM state typedef and the default DEVICE_ID constant 8'h42; these are shared with SCCB_Master.
REQ-031 One sub-module, SCCB_sync_edge, provides the synchronizer and the rise/fall edge flags; it is instantiated once each for SIO_C and SIO_D.

Verification
REQ-032 Write 0x42, 0x12, 0x80 at 100 kHz SIO_C:
- Three ACK lows are observed.
- o_wr_en pulses once, with addr 0x12 and data 0x80.
REQ-033 ID 0x60: o_id_error pulses, SIO_D stays Z for all 9th bits, no o_wr_en, o_busy falls at STOP.
REQ-034 STOP after the 4th bit of the data byte: no o_wr_en, state IDLE, addr/data hold their previous values.
REQ-035 Repeated START after the address ACK, then 0x42, 0x3A, 0x04, STOP: one o_wr_en, with addr 0x3A and data 0x04.
REQ-036 Reset asserted during ADDR_BYTE:
- Outputs go to 0 and SIO_D to Z.
- The following full write 0x42, 0x11, 0x00 completes normally.
REQ-037 SIO_D glitch of 1 clk while SIO_C is high is filtered by the synchronizer: no START and no STOP is detected.
